led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Plays an 8-step on/off blink pattern on one LED.
- Each step lasts a programmable number of clock cycles; the pattern replays a commanded number of times or until aborted.
- Accepts commands over a valid/ready handshake, so several software/FSM sources can reuse the LED without retiming logic.
- Sits between the board clock and the led0 pin; replaces ad-hoc free-running divider-plus-counter blink logic.

Parameters:
- CLK_DIV, 2500000, clock cycles per pattern step; must be >= 2.
- CNT_W, $clog2(CLK_DIV), step-divider counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command; high exactly when state == IDLE.
- cmd_pattern  input  8  step bitmap; bit0 plays first, bit7 last; 1 = LED on.
- cmd_repeat  input  4  number of full plays; 0 = play forever until abort.
- abort  input  1  stop current play.
- led0  output  1  LED drive, registered.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: state IDLE, led0 = 0, busy = 0, done = 0, cmd_ready = 1, step_idx = 0, rep_left = 0, divider count = 0. Reset takes effect mid-play immediately, with no clock edge needed.
- FSM states:
  - IDLE: cmd_ready = 1, led0 = 0.
  - RUN: cmd_ready = 0, busy = 1.
- Accept: at an edge where cmd_valid && cmd_ready, the block:
  - latches pattern and rep_left = cmd_repeat;
  - sets step_idx = 0;
  - clears the divider;
  - drives led0 = cmd_pattern[0] from that edge on;
  - enters RUN.
- Step timing:
  - The divider counts 0..CLK_DIV-1 in RUN. tick is high in the cycle where count == CLK_DIV-1, and count wraps to 0 on the next edge.
  - Each step holds led0 for exactly CLK_DIV cycles. One full play = 8*CLK_DIV cycles.
- On tick with step_idx < 7: step_idx++ and led0 = pattern[step_idx+1].
- On tick with step_idx == 7:
  - rep_left == 1: go to IDLE, led0 = 0, done = 1 for that one cycle, cmd_ready = 1 in the same cycle.
  - rep_left == 0 (infinite): step_idx = 0, led0 = pattern[0], stay in RUN.
  - otherwise: rep_left--, step_idx = 0, led0 = pattern[0], stay in RUN.
- Abort:
  - In RUN: next edge goes to IDLE, led0 = 0, divider cleared, done stays 0. Abort has priority over a coincident tick.
  - In IDLE: ignored. A coincident abort and valid command in IDLE are handled as an accept.
- Back-to-back: a command held valid during RUN is accepted at the first edge after done rises. This gives a 1-cycle led0 = 0 gap between plays.
- cmd_pattern and cmd_repeat are sampled only at accept. Changes during RUN have no effect.
- Divider runs only in RUN, which saves toggling in IDLE.

Decomposition:
- Shared package led_pkg:
  - state enum {IDLE, RUN};
  - PATTERN_W = 8;
  - REPEAT_W = 4;
  - REPEAT_INFINITE = 0.
- One sub-module, step_tick_gen:
  - parameter CLK_DIV;
  - ports clk, rst_n, clr, en, tick;
  - mod-CLK_DIV counter with 1-cycle tick.
- FSM, step index, repeat counter and led0 register live in the top.

Test Plan:
- Single play: CLK_DIV=4, pattern 8'b1010_0110, repeat 1.
  - led0 = 0,1,1,0,0,1,0,1, each held 4 cycles, starting the edge after accept.
  - done = 1 exactly 32 cycles after accept; led0 = 0 and cmd_ready = 1 in that same cycle.
- Repeat: pattern 8'hFF, repeat 3 -> led0 = 1 continuously for 96 cycles, exactly one done pulse, busy low afterwards.
- Infinite + abort: pattern 8'h0F, repeat 0, abort pulsed 50 cycles after accept -> led0 = 0 and busy = 0 on the next edge, done never asserts, cmd_ready = 1.
- Backpressure/back-to-back: cmd_valid held high with a second pattern 8'h01 during a repeat-1 play -> cmd_ready stays 0 during RUN, second command accepted at the done cycle, led0 = 1 one cycle later for 4 cycles.
- Async reset mid-run: rst_n dropped between edges at cycle 13 of a play -> led0 = 0, busy = 0, cmd_ready = 1 immediately. After release, a new command replays from step 0 with full-length steps.
- Coincident events:
  - abort and tick in the same cycle at step 7 with repeat 1 -> IDLE with done = 0.
  - abort plus cmd_valid in IDLE -> command accepted.

Source files
------------

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED pattern sequencer.
//   state_e          : sequencer FSM states (IDLE, RUN)
//   PATTERN_W        : width of the on/off step bitmap
//   REPEAT_W         : width of the play-count field
//   REPEAT_INFINITE  : play-count value meaning "replay until aborted"
//   STEP_W/LAST_STEP : step index width and index of the final step
// ----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int PATTERN_W = 8;
   localparam int REPEAT_W  = 4;
   localparam int STEP_W    = 3;

   localparam logic [REPEAT_W-1:0] REPEAT_INFINITE = 4'd0;
   localparam logic [REPEAT_W-1:0] REPEAT_LAST     = 4'd1;
   localparam logic [STEP_W-1:0]   LAST_STEP       = 3'd7;

endpackage : led_pkg

// File: rtl/led_pattern_sequencer_step_tick_gen.sv
// ----------------------------------------------------------------------------
// step_tick_gen
// Modulo-CLK_DIV step divider. Counts 0..CLK_DIV-1 while enabled and raises
// tick for the single cycle in which the count sits at CLK_DIV-1; the count
// wraps to 0 on the following edge. The counter holds when disabled.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear of the count (wins over en)
//   en    : count enable
//   tick  : one-cycle pulse at the last count of each step
// ----------------------------------------------------------------------------
module step_tick_gen #(
   parameter int CLK_DIV = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int              CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tick = en && (count_q == CNT_LAST);

   // Next count: clear, wrap at the last count, increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = CNT_ZERO;
      end else if (en) begin
         if (count_q == CNT_LAST) begin
            count_d = CNT_ZERO;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Divider count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : step_tick_gen

// File: rtl/led_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// led_pattern_sequencer
// Plays an 8-step on/off blink pattern on one LED. Each step lasts CLK_DIV
// clock cycles; the pattern replays cmd_repeat times (0 = until abort).
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   cmd_valid   : command present
//   cmd_ready   : command can be accepted (high exactly in IDLE)
//   cmd_pattern : step bitmap, bit0 plays first, 1 = LED on
//   cmd_repeat  : number of full plays, 0 = forever
//   abort       : stop the current play (ignored in IDLE)
//   led0        : registered LED drive
//   busy        : high while playing
//   done        : one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int CLK_DIV = 2500000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [PATTERN_W-1:0] cmd_pattern,
   input  logic [REPEAT_W-1:0]  cmd_repeat,
   input  logic                 abort,
   output logic                 led0,
   output logic                 busy,
   output logic                 done
);

   state_e                 state_q,   state_d;
   logic [PATTERN_W-1:0]   pattern_q, pattern_d;
   logic [REPEAT_W-1:0]    rep_q,     rep_d;
   logic [STEP_W-1:0]      step_q,    step_d;
   logic                   led_q,     led_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;
   logic                   clr_s;
   logic                   en_s;
   logic                   tick_s;
   logic [STEP_W-1:0]      next_step_s;

   // The divider only runs in RUN; it is cleared on accept and on abort so
   // every play starts with a full-length first step.
   assign en_s        = (state_q == RUN);
   assign next_step_s = step_q + 3'd1;

   step_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_step_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .en    (en_s),
      .tick  (tick_s)
   );

   // FSM next state, step/repeat bookkeeping and next LED value.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      rep_d     = rep_q;
      step_d    = step_q;
      led_d     = led_q;
      done_d    = 1'b0;
      clr_s     = 1'b0;
      case (state_q)
         IDLE: begin
            led_d = 1'b0;
            // abort is deliberately not looked at here: a coincident abort
            // and command in IDLE is an ordinary accept.
            if (cmd_valid) begin
               state_d   = RUN;
               pattern_d = cmd_pattern;
               rep_d     = cmd_repeat;
               step_d    = 3'd0;
               led_d     = cmd_pattern[0];
               clr_s     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               // Abort wins over a tick in the same cycle, so no done pulse.
               state_d = IDLE;
               step_d  = 3'd0;
               rep_d   = 4'd0;
               led_d   = 1'b0;
               clr_s   = 1'b1;
            end else if (tick_s) begin
               if (step_q != LAST_STEP) begin
                  step_d = next_step_s;
                  led_d  = pattern_q[next_step_s];
               end else if (rep_q == REPEAT_LAST) begin
                  state_d = IDLE;
                  step_d  = 3'd0;
                  rep_d   = 4'd0;
                  led_d   = 1'b0;
                  done_d  = 1'b1;
               end else if (rep_q == REPEAT_INFINITE) begin
                  step_d = 3'd0;
                  led_d  = pattern_q[0];
               end else begin
                  rep_d  = rep_q - 4'd1;
                  step_d = 3'd0;
                  led_d  = pattern_q[0];
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = 3'd0;
            rep_d   = 4'd0;
            led_d   = 1'b0;
            clr_s   = 1'b1;
         end
      endcase
      busy_d = (state_d == RUN);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pattern_q <= 8'd0;
         rep_q     <= 4'd0;
         step_q    <= 3'd0;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         rep_q     <= rep_d;
         step_q    <= step_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // cmd_ready is a pure decode of the state register.
   assign cmd_ready = (state_q == IDLE);
   assign led0      = led_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule : led_pattern_sequencer
